// File: rtl/dmem_portb_arbiter.sv
// dmem_portb_arbiter: owns port B of the shared data memory, arbitrating CCD writes against ACC reads/writes.
// Define ARB_PERF_CNT_EN to build the per-requester stall counters; otherwise both read as zero.
module dmem_portb_arbiter #(
  parameter int ADDR_W        = 7,
  parameter int DATA_W        = 256,
  parameter int RD_LATENCY    = 2,
  parameter int CCD_BURST_MAX = 8,
  parameter int LOCK_TIMEOUT  = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ccd_req,
  input  logic [ADDR_W-1:0] ccd_addr,
  input  logic [DATA_W-1:0] ccd_wrdata,
  output logic              ccd_gnt,
  input  logic              acc_req,
  input  logic              acc_wren,
  input  logic              acc_lock,
  input  logic [ADDR_W-1:0] acc_addr,
  input  logic [DATA_W-1:0] acc_wrdata,
  output logic              acc_gnt,
  output logic [DATA_W-1:0] acc_rdata,
  output logic              acc_rvalid,
  output logic              acc_lock_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  output logic              ram_rden,
  input  logic [DATA_W-1:0] ram_q,
  output logic [15:0]       ccd_stall_cnt,
  output logic [15:0]       acc_stall_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CCD      = 2'd1,
    ST_ACC      = 2'd2,
    ST_ACC_LOCK = 2'd3
  } state_e;

  localparam int BURST_W = $clog2(CCD_BURST_MAX + 1);
  localparam int LOCK_W  = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [BURST_W-1:0] BURST_MAX_C = BURST_W'(CCD_BURST_MAX);
  localparam logic [LOCK_W-1:0]  LOCK_LAST_C = LOCK_W'(LOCK_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                lock_ign_q, lock_ign_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_data_q, ram_data_d;
  logic                ram_wren_q, ram_wren_d;
  logic                ram_rden_q, ram_rden_d;
  logic [RD_LATENCY:0] rd_pipe_q, rd_pipe_d;

  logic ccd_gnt_s, acc_gnt_s, lock_brk_s, starving_s, lock_eff_s;

  // Grant decision and next owner; the lock is broken in the cycle the contested count reaches the timeout.
  always_comb begin
    starving_s = (burst_cnt_q == BURST_MAX_C) && acc_req;
    lock_eff_s = acc_lock && !lock_ign_q;
    ccd_gnt_s  = 1'b0;
    acc_gnt_s  = 1'b0;
    lock_brk_s = 1'b0;
    state_d    = ST_IDLE;
    if (rst) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_ACC_LOCK: begin
          if (ccd_req && (lock_cnt_q == LOCK_LAST_C)) begin
            lock_brk_s = 1'b1;
            state_d    = ST_IDLE;
          end else if (acc_req) begin
            acc_gnt_s = 1'b1;
            state_d   = lock_eff_s ? ST_ACC_LOCK : ST_ACC;
          end else if (lock_eff_s) begin
            state_d = ST_ACC_LOCK;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_IDLE, ST_CCD, ST_ACC: begin
          if (ccd_req && !starving_s) begin
            ccd_gnt_s = 1'b1;
            state_d   = ST_CCD;
          end else if (acc_req) begin
            acc_gnt_s = 1'b1;
            state_d   = lock_eff_s ? ST_ACC_LOCK : ST_ACC;
          end else begin
            state_d = ST_IDLE;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Fairness/lock bookkeeping and the RAM issue stage contents for the next cycle.
  always_comb begin
    if ((state_q == ST_ACC_LOCK) && (state_d == ST_ACC_LOCK)) begin
      lock_cnt_d = ccd_req ? (lock_cnt_q + LOCK_W'(1)) : lock_cnt_q;
    end else begin
      lock_cnt_d = '0;
    end

    if (!acc_req || acc_gnt_s) begin
      burst_cnt_d = '0;
    end else if (ccd_gnt_s && (burst_cnt_q != BURST_MAX_C)) begin
      burst_cnt_d = burst_cnt_q + BURST_W'(1);
    end else begin
      burst_cnt_d = burst_cnt_q;
    end

    // After a forced break, acc_lock stays ignored until the accelerator drops its request once.
    if (lock_brk_s) begin
      lock_ign_d = 1'b1;
    end else if (!acc_req) begin
      lock_ign_d = 1'b0;
    end else begin
      lock_ign_d = lock_ign_q;
    end

    if (ccd_gnt_s) begin
      ram_addr_d = ccd_addr;
      ram_data_d = ccd_wrdata;
      ram_wren_d = 1'b1;
      ram_rden_d = 1'b0;
    end else if (acc_gnt_s) begin
      ram_addr_d = acc_addr;
      ram_data_d = acc_wrdata;
      ram_wren_d = acc_wren;
      ram_rden_d = !acc_wren;
    end else begin
      ram_addr_d = ram_addr_q;
      ram_data_d = ram_data_q;
      ram_wren_d = 1'b0;
      ram_rden_d = 1'b0;
    end

    rd_pipe_d = {rd_pipe_q[RD_LATENCY-1:0], acc_gnt_s && !acc_wren};
  end

  // State, counters, issue stage and read-return tracker.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      burst_cnt_q <= '0;
      lock_cnt_q  <= '0;
      lock_ign_q  <= 1'b0;
      ram_addr_q  <= '0;
      ram_data_q  <= '0;
      ram_wren_q  <= 1'b0;
      ram_rden_q  <= 1'b0;
      rd_pipe_q   <= '0;
    end else begin
      state_q     <= state_d;
      burst_cnt_q <= burst_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      lock_ign_q  <= lock_ign_d;
      ram_addr_q  <= ram_addr_d;
      ram_data_q  <= ram_data_d;
      ram_wren_q  <= ram_wren_d;
      ram_rden_q  <= ram_rden_d;
      rd_pipe_q   <= rd_pipe_d;
    end
  end

  assign ccd_gnt      = ccd_gnt_s;
  assign acc_gnt      = acc_gnt_s;
  assign acc_lock_err = lock_brk_s;
  assign ram_addr     = ram_addr_q;
  assign ram_data     = ram_data_q;
  // An access whose issue cycle coincides with reset never reaches the RAM.
  assign ram_wren     = ram_wren_q && !rst;
  assign ram_rden     = ram_rden_q && !rst;
  assign acc_rvalid   = rd_pipe_q[RD_LATENCY];
  assign acc_rdata    = ram_q;

`ifdef ARB_PERF_CNT_EN
  logic [15:0] ccd_stall_q;
  logic [15:0] acc_stall_q;

  // Saturating stall counters: a cycle with a pending request that was not granted.
  always_ff @(posedge clk) begin
    if (rst) begin
      ccd_stall_q <= 16'h0000;
      acc_stall_q <= 16'h0000;
    end else begin
      if (ccd_req && !ccd_gnt_s && (ccd_stall_q != 16'hFFFF)) begin
        ccd_stall_q <= ccd_stall_q + 16'd1;
      end
      if (acc_req && !acc_gnt_s && (acc_stall_q != 16'hFFFF)) begin
        acc_stall_q <= acc_stall_q + 16'd1;
      end
    end
  end

  assign ccd_stall_cnt = ccd_stall_q;
  assign acc_stall_cnt = acc_stall_q;
`else
  assign ccd_stall_cnt = 16'h0000;
  assign acc_stall_cnt = 16'h0000;
`endif

endmodule
